// File: rtl/jam_pkg.sv
// Shared FSM encoding, default datapath sizes and the perm_job slicing helper
// for the job-assignment (JAM) search scheduler.
package jam_pkg;

  localparam int N_DEF     = 8;
  localparam int IW_DEF    = 3;
  localparam int CW_DEF    = 7;
  localparam int SW_DEF    = 10;
  localparam int MW_DEF    = 4;
  localparam int PERM_MAXW = 64;
  localparam int IDX_MAXW  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CMP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Job index of worker idx inside a packed perm_job vector of iw-bit entries.
  function automatic logic [IDX_MAXW-1:0] perm_slice(
    input logic [PERM_MAXW-1:0] vec,
    input int unsigned          idx,
    input int unsigned          iw
  );
    logic [PERM_MAXW-1:0] w_shift;
    w_shift = vec >> (idx * iw);
    return w_shift[IDX_MAXW-1:0] & ((8'd1 << iw) - 8'd1);
  endfunction

endpackage

// File: rtl/jam_cost_accum.sv
// Per-permutation cost accumulator with running minimum and a saturating
// count of permutations that tie at that minimum.
module jam_cost_accum
  import jam_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int SW = SW_DEF,
  parameter int MW = MW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          i_clr_all,
  input  logic          i_clr_sum,
  input  logic          i_add,
  input  logic          i_cmp,
  input  logic [CW-1:0] i_cost,
  output logic [SW-1:0] o_min_cost,
  output logic [MW-1:0] o_match_count
);

  localparam logic [MW-1:0] CNT_MAX = {MW{1'b1}};

  logic [SW-1:0] r_sum;
  logic [SW-1:0] r_min;
  logic [MW-1:0] r_cnt;
  logic          r_first;

  // Sum clears while waiting for a permutation; the compare happens once per permutation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sum   <= {SW{1'b0}};
      r_min   <= {SW{1'b1}};
      r_cnt   <= {MW{1'b0}};
      r_first <= 1'b1;
    end else begin
      if (i_clr_sum) begin
        r_sum <= {SW{1'b0}};
      end else if (i_add) begin
        r_sum <= r_sum + SW'(i_cost);
      end
      if (i_clr_all) begin
        r_min   <= {SW{1'b1}};
        r_cnt   <= {MW{1'b0}};
        r_first <= 1'b1;
      end else if (i_cmp) begin
        if (r_first || (r_sum < r_min)) begin
          r_min   <= r_sum;
          r_cnt   <= MW'(1);
          r_first <= 1'b0;
        end else if ((r_sum == r_min) && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + MW'(1);
        end
      end
    end
  end

  assign o_min_cost    = r_min;
  assign o_match_count = r_cnt;

endmodule

// File: rtl/jam_perm_scheduler.sv
// Sequences one complete JAM search: permutation handshake, Cost ROM address
// sweep, cost accumulation and the final result strobe.
module jam_perm_scheduler
  import jam_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = IW_DEF,
  parameter int CW = CW_DEF,
  parameter int SW = SW_DEF,
  parameter int MW = MW_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            start,
  output logic            perm_req,
  input  logic            perm_vld,
  input  logic            perm_last,
  input  logic [N*IW-1:0] perm_job,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   Cost,
  output logic [MW-1:0]   MatchCount,
  output logic [SW-1:0]   MinCost,
  output logic            Valid,
  output logic            busy
);

  localparam logic [IW-1:0] K_LAST = IW'(N - 1);

  state_t          r_state;
  logic [N*IW-1:0] r_perm;
  logic [IW-1:0]   r_k;
  logic [IW-1:0]   r_w;
  logic [IW-1:0]   r_j;
  logic            r_req;
  logic            r_valid;
  logic            r_busy;
  logic            r_last_seen;
  logic            w_accept;
  logic            w_clr_all;
  logic            w_clr_sum;
  logic            w_add;
  logic            w_cmp;

  function automatic logic [IW-1:0] job_of(input logic [N*IW-1:0] vec, input int unsigned k);
    return IW'(perm_slice(PERM_MAXW'(vec), k, IW));
  endfunction

  assign w_accept  = (r_state == ST_REQ) && r_req && perm_vld;
  assign w_clr_all = (r_state == ST_IDLE) && start;
  assign w_clr_sum = (r_state == ST_REQ);
  // Cost lags the address by one cycle, so FETCH k=0 has nothing to add yet.
  assign w_add     = ((r_state == ST_FETCH) && (r_k != {IW{1'b0}})) || (r_state == ST_DRAIN);
  assign w_cmp     = (r_state == ST_CMP);

  // Search sequencer: generator handshake, ROM address sweep and result strobe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_perm      <= {(N*IW){1'b0}};
      r_k         <= {IW{1'b0}};
      r_w         <= {IW{1'b0}};
      r_j         <= {IW{1'b0}};
      r_req       <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_last_seen <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_REQ;
            r_busy  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (w_accept) begin
            r_req       <= 1'b0;
            r_perm      <= perm_job;
            r_last_seen <= perm_last;
            r_k         <= {IW{1'b0}};
            r_w         <= {IW{1'b0}};
            r_j         <= job_of(perm_job, 32'd0);
            r_state     <= ST_FETCH;
          end else begin
            r_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (r_k == K_LAST) begin
            r_state <= ST_DRAIN;
          end else begin
            r_k <= r_k + IW'(1);
            r_w <= r_k + IW'(1);
            r_j <= job_of(r_perm, 32'(r_k) + 32'd1);
          end
        end
        ST_DRAIN: r_state <= ST_CMP;
        ST_CMP: begin
          if (r_last_seen) begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
          end else begin
            r_state <= ST_REQ;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  jam_cost_accum #(
    .CW(CW),
    .SW(SW),
    .MW(MW)
  ) u_accum (
    .CLK          (CLK),
    .RST          (RST),
    .i_clr_all    (w_clr_all),
    .i_clr_sum    (w_clr_sum),
    .i_add        (w_add),
    .i_cmp        (w_cmp),
    .i_cost       (Cost),
    .o_min_cost   (MinCost),
    .o_match_count(MatchCount)
  );

  assign perm_req = r_req;
  assign W        = r_w;
  assign J        = r_j;
  assign Valid    = r_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_jam_perm_scheduler.sv
// Bench for jam_perm_scheduler: an N=3 and an N=8 instance, a registered Cost ROM
// model, a permutation generator and a reference that scores whole permutations.
module tb_jam_perm_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start3, start8, vld3, vld8, last3, last8;
  logic [5:0]  job3;
  logic [23:0] job8;
  logic        req3, req8, valid3, valid8, busy3, busy8;
  logic [1:0]  w3, j3;
  logic [2:0]  w8, j8;
  logic [6:0]  cost3, cost8;
  logic [3:0]  cnt3, cnt8;
  logic [9:0]  min3, min8;

  int rom3[3][3];
  int rom8[8][8];
  int pm[32][8];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cost3 <= 7'(rom3[w3][j3]);
    cost8 <= 7'(rom8[w8][j8]);
  end

  jam_perm_scheduler #(.N(3), .IW(2), .CW(7), .SW(10), .MW(4)) u3 (
    .CLK(clk), .RST(rst), .start(start3), .perm_req(req3), .perm_vld(vld3),
    .perm_last(last3), .perm_job(job3), .W(w3), .J(j3), .Cost(cost3),
    .MatchCount(cnt3), .MinCost(min3), .Valid(valid3), .busy(busy3)
  );

  jam_perm_scheduler #(.N(8), .IW(3), .CW(7), .SW(10), .MW(4)) u8 (
    .CLK(clk), .RST(rst), .start(start8), .perm_req(req8), .perm_vld(vld8),
    .perm_last(last8), .perm_job(job8), .W(w8), .J(j8), .Cost(cost8),
    .MatchCount(cnt8), .MinCost(min8), .Valid(valid8), .busy(busy8)
  );

  function automatic logic get_req(bit big);   return big ? req8 : req3;     endfunction
  function automatic logic get_valid(bit big); return big ? valid8 : valid3; endfunction
  function automatic logic get_busy(bit big);  return big ? busy8 : busy3;   endfunction
  function automatic int get_w(bit big);   return big ? int'(w8) : int'(w3);     endfunction
  function automatic int get_min(bit big); return big ? int'(min8) : int'(min3); endfunction
  function automatic int get_cnt(bit big); return big ? int'(cnt8) : int'(cnt3); endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_perms(int n, int np);
    int j, tmp;
    for (int p = 0; p < np; p++) begin
      for (int w = 0; w < n; w++) pm[p][w] = w;
      for (int i = n - 1; i > 0; i--) begin
        j = $urandom_range(0, i);
        tmp = pm[p][i]; pm[p][i] = pm[p][j]; pm[p][j] = tmp;
      end
    end
  endtask

  task automatic gen_lex3();
    int lex[6][3] = '{'{0,1,2}, '{0,2,1}, '{1,0,2}, '{1,2,0}, '{2,0,1}, '{2,1,0}};
    for (int p = 0; p < 6; p++)
      for (int w = 0; w < 3; w++) pm[p][w] = lex[p][w];
  endtask

  // Reference: score each permutation as a whole, keep min and saturating tie count.
  task automatic model(bit big, int np, output int emin, output int ecnt);
    int s;
    emin = 0; ecnt = 0;
    for (int p = 0; p < np; p++) begin
      s = 0;
      if (big) for (int w = 0; w < 8; w++) s += rom8[w][pm[p][w]];
      else     for (int w = 0; w < 3; w++) s += rom3[w][pm[p][w]];
      if (p == 0 || s < emin) begin emin = s; ecnt = 1; end
      else if (s == emin && ecnt < 15) ecnt++;
    end
  endtask

  task automatic drive_perm(bit big, int p, bit last);
    if (big) begin
      vld8 = 1'b1; last8 = last; job8 = '0;
      for (int w = 0; w < 8; w++) job8[w*3 +: 3] = 3'(pm[p][w]);
    end else begin
      vld3 = 1'b1; last3 = last; job3 = '0;
      for (int w = 0; w < 3; w++) job3[w*2 +: 2] = 2'(pm[p][w]);
    end
  endtask

  task automatic run_search(bit big, int np, int dly_mode, bit glitch, string name);
    int n, emin, ecnt, t, d;
    n = big ? 8 : 3;
    model(big, np, emin, ecnt);
    if (big) start8 = 1'b1; else start3 = 1'b1;
    tick();
    start8 = 1'b0; start3 = 1'b0;
    for (int p = 0; p < np; p++) begin
      t = 0;
      while (get_req(big) !== 1'b1 && t < 50) begin tick(); t++; end
      n_cmp++;
      if (get_req(big) !== 1'b1) begin
        n_bad++; $display("FAIL %s req_timeout perm=%0d got=%0b want=1", name, p, get_req(big));
      end
      d = (dly_mode < 0) ? int'($urandom_range(0, 5)) : dly_mode;
      for (int i = 0; i < d; i++) begin
        tick();
        n_cmp++;
        if (get_req(big) !== 1'b1) begin
          n_bad++; $display("FAIL %s req_hold perm=%0d got=%0b want=1", name, p, get_req(big));
        end
      end
      drive_perm(big, p, p == np - 1);
      tick();
      vld3 = 1'b0; vld8 = 1'b0; last3 = 1'b0; last8 = 1'b0;
      n_cmp++;
      if (get_req(big) !== 1'b0) begin
        n_bad++; $display("FAIL %s req_drop perm=%0d got=%0b want=0", name, p, get_req(big));
      end
      for (int k = 0; k < n; k++) begin
        n_cmp++;
        if (get_w(big) !== k) begin
          n_bad++; $display("FAIL %s w_sweep perm=%0d got=%0d want=%0d", name, p, get_w(big), k);
        end
        if (glitch && k == 2) begin
          if (big) start8 = 1'b1; else start3 = 1'b1;
        end
        tick();
        start8 = 1'b0; start3 = 1'b0;
        if (glitch && k == 2) begin
          n_cmp++;
          if (get_busy(big) !== 1'b1) begin
            n_bad++; $display("FAIL %s busy_glitch got=%0b want=1", name, get_busy(big));
          end
        end
      end
    end
    t = 0;
    while (get_valid(big) !== 1'b1 && t < 100) begin tick(); t++; end
    n_cmp++;
    if (get_valid(big) !== 1'b1) begin
      n_bad++; $display("FAIL %s valid_timeout got=0 want=1", name);
    end else begin
      n_cmp++;
      if (get_min(big) !== emin) begin
        n_bad++; $display("FAIL %s min_cost got=%0d want=%0d", name, get_min(big), emin);
      end
      n_cmp++;
      if (get_cnt(big) !== ecnt) begin
        n_bad++; $display("FAIL %s match_count got=%0d want=%0d", name, get_cnt(big), ecnt);
      end
      tick();
      n_cmp++;
      if (get_valid(big) !== 1'b0 || get_busy(big) !== 1'b0) begin
        n_bad++; $display("FAIL %s valid_pulse_end got=%0b%0b want=00", name, get_valid(big), get_busy(big));
      end
      tick();
      n_cmp++;
      if (get_min(big) !== emin || get_cnt(big) !== ecnt) begin
        n_bad++; $display("FAIL %s hold got=%0d/%0d want=%0d/%0d", name, get_min(big), get_cnt(big), emin, ecnt);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start3 = 1'b0; start8 = 1'b0; vld3 = 1'b0; vld8 = 1'b0;
    last3 = 1'b0; last8 = 1'b0; job3 = '0; job8 = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int b = 0; b < 2; b++) begin
      n_cmp++;
      if (get_min(b[0]) !== 1023 || get_cnt(b[0]) !== 0 || get_req(b[0]) !== 1'b0 ||
          get_valid(b[0]) !== 1'b0 || get_busy(b[0]) !== 1'b0 || get_w(b[0]) !== 0) begin
        n_bad++;
        $display("FAIL reset_state inst=%0d got min=%0d cnt=%0d req=%0b valid=%0b busy=%0b w=%0d want 1023/0/0/0/0/0",
                 b, get_min(b[0]), get_cnt(b[0]), get_req(b[0]), get_valid(b[0]), get_busy(b[0]), get_w(b[0]));
      end
    end
    vld8 = 1'b1; last8 = 1'b1;
    tick();
    vld8 = 1'b0; last8 = 1'b0;
    tick();
    n_cmp++;
    if (busy8 !== 1'b0 || req8 !== 1'b0 || valid8 !== 1'b0) begin
      n_bad++; $display("FAIL idle_vld_ignored got busy=%0b req=%0b valid=%0b want 0/0/0", busy8, req8, valid8);
    end
  endtask

  task automatic test_uniform3();
    for (int w = 0; w < 3; w++) for (int j = 0; j < 3; j++) rom3[w][j] = j + 1;
    gen_lex3();
    run_search(1'b0, 6, -1, 1'b0, "uniform3");
  endtask

  task automatic test_diag3();
    for (int w = 0; w < 3; w++) for (int j = 0; j < 3; j++) rom3[w][j] = (w == j) ? 1 : 9;
    gen_lex3();
    run_search(1'b0, 6, -1, 1'b0, "diag3");
  endtask

  task automatic test_saturate();
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) rom8[w][j] = 127;
    gen_perms(8, 20);
    run_search(1'b1, 20, -1, 1'b0, "saturate");
  endtask

  task automatic test_handshake();
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) rom8[w][j] = $urandom_range(0, 127);
    gen_perms(8, 2);
    run_search(1'b1, 2, 0, 1'b0, "hs_d0");
    run_search(1'b1, 2, 1, 1'b0, "hs_d1");
    run_search(1'b1, 2, 5, 1'b0, "hs_d5");
  endtask

  task automatic test_single();
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) rom8[w][j] = w + 1;
    gen_perms(8, 1);
    run_search(1'b1, 1, 2, 1'b1, "single");
  endtask

  task automatic test_reset_mid();
    int t;
    for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) rom8[w][j] = $urandom_range(0, 127);
    gen_perms(8, 3);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    t = 0;
    while (req8 !== 1'b1 && t < 20) begin tick(); t++; end
    drive_perm(1'b1, 0, 1'b0);
    tick();
    vld8 = 1'b0;
    t = 0;
    while (w8 !== 3'd4 && t < 20) begin tick(); t++; end
    n_cmp++;
    if (w8 !== 3'd4 || busy8 !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_reach got w=%0d busy=%0b want 4/1", w8, busy8);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (req8 !== 1'b0 || min8 !== 10'd1023 || cnt8 !== 4'd0 || busy8 !== 1'b0 || w8 !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_mid got req=%0b min=%0d cnt=%0d busy=%0b w=%0d want 0/1023/0/0/0", req8, min8, cnt8, busy8, w8);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    run_search(1'b1, 3, -1, 1'b0, "post_rst");
  endtask

  task automatic test_random();
    int np;
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 8; w++) for (int j = 0; j < 8; j++) rom8[w][j] = $urandom_range(0, 3);
      np = $urandom_range(1, 10);
      gen_perms(8, np);
      run_search(1'b1, np, -1, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_uniform3();
    test_diag3();
    test_saturate();
    test_handshake();
    test_single();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
